// File: rtl/bp_pht_port_ctrl.sv
// Pattern-history-table port controller: post-reset init sweep, buffered
// read-modify-write updates, and per-cycle lookup/update arbitration.
module bp_pht_port_ctrl #(
    parameter int IDX_BITS   = 8,
    parameter int CTR_BITS   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int INIT_VAL   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          lk_valid,
    input  logic [IDX_BITS-1:0]           lk_idx,
    output logic                          lk_ready,
    output logic                          lk_rvalid,
    output logic [CTR_BITS-1:0]           lk_rdata,
    input  logic                          upd_valid,
    input  logic [IDX_BITS-1:0]           upd_idx,
    input  logic                          upd_taken,
    output logic                          upd_ready,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [IDX_BITS-1:0]           mem_addr,
    output logic [CTR_BITS-1:0]           mem_wdata,
    input  logic [CTR_BITS-1:0]           mem_rdata,
    output logic                          init_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_UPD_WB
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_BITS-1:0]  sweep_q, sweep_d;
    logic                 init_done_q, init_done_d;
    logic                 lk_rvalid_q;
    logic [CTR_BITS-1:0]  lk_rdata_q;

    logic [IDX_BITS-1:0]  fifo_idx_q [FIFO_DEPTH];
    logic                 fifo_tkn_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                 full, empty, push, pop, lk_grant, upd_rdy_c;
    logic                 en_c, we_c;
    logic [IDX_BITS-1:0]  addr_c;
    logic [CTR_BITS-1:0]  wdata_c, new_ctr;
    logic [IDX_BITS-1:0]  head_idx;
    logic                 head_tkn;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign head_idx  = fifo_idx_q[rd_ptr_q];
    assign head_tkn  = fifo_tkn_q[rd_ptr_q];
    assign upd_rdy_c = init_done_q && !full;
    assign push      = upd_valid && upd_rdy_c;

    always_comb begin
        new_ctr = mem_rdata;
        if (head_tkn) begin
            if (mem_rdata != '1) new_ctr = mem_rdata + 1'b1;
        end else begin
            if (mem_rdata != '0) new_ctr = mem_rdata - 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        init_done_d = init_done_q;
        lk_grant    = 1'b0;
        pop         = 1'b0;
        en_c        = 1'b0;
        we_c        = 1'b0;
        addr_c      = '0;
        wdata_c     = '0;
        case (state_q)
            S_INIT: begin
                en_c    = 1'b1;
                we_c    = 1'b1;
                addr_c  = sweep_q;
                wdata_c = CTR_BITS'(INIT_VAL);
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == '1) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                // Lookups win unless the update queue is full.
                if (lk_valid && !full) begin
                    lk_grant = 1'b1;
                    en_c     = 1'b1;
                    addr_c   = lk_idx;
                end else if (!empty) begin
                    en_c    = 1'b1;
                    addr_c  = head_idx;
                    state_d = S_UPD_WB;
                end
            end
            S_UPD_WB: begin
                en_c    = 1'b1;
                we_c    = 1'b1;
                addr_c  = head_idx;
                wdata_c = new_ctr;
                pop     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            sweep_q     <= '0;
            init_done_q <= 1'b0;
            lk_rvalid_q <= 1'b0;
            lk_rdata_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            init_done_q <= init_done_d;
            lk_rvalid_q <= lk_grant;
            if (lk_rvalid_q) lk_rdata_q <= mem_rdata;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q] <= upd_idx;
            fifo_tkn_q[wr_ptr_q] <= upd_taken;
        end
    end

    // Read data is passed straight through in the valid cycle and held afterwards.
    assign lk_rdata   = lk_rvalid_q ? mem_rdata : lk_rdata_q;
    assign lk_rvalid  = lk_rvalid_q;
    assign init_done  = init_done_q;
    assign fifo_count = reset ? '0 : count_q;
    assign lk_ready   = !reset && lk_grant;
    assign upd_ready  = !reset && upd_rdy_c;
    assign mem_en     = !reset && en_c;
    assign mem_we     = !reset && we_c;
    assign mem_addr   = reset ? '0 : addr_c;
    assign mem_wdata  = reset ? '0 : wdata_c;

endmodule

// File: tb/tb_bp_pht_port_ctrl.sv
// Scoreboard bench for bp_pht_port_ctrl: expected memory writes and lookup
// data are queued by the stimulus and consumed by a negedge monitor.
module tb_bp_pht_port_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       lk_valid;
    logic [7:0] lk_idx;
    logic       lk_ready, lk_rvalid;
    logic [1:0] lk_rdata;
    logic       upd_valid;
    logic [7:0] upd_idx;
    logic       upd_taken;
    logic       upd_ready;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;
    logic       init_done;
    logic [2:0] fifo_count;

    logic [1:0] tbl [256];
    logic [9:0] exp_wr [$];
    logic [1:0] exp_lk [$];
    int checks = 0;
    int errors = 0;

    bp_pht_port_ctrl #(
        .IDX_BITS(8), .CTR_BITS(2), .FIFO_DEPTH(4), .INIT_VAL(1)
    ) dut (
        .clk(clk), .reset(reset),
        .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_ready(lk_ready),
        .lk_rvalid(lk_rvalid), .lk_rdata(lk_rdata),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_ready(upd_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .init_done(init_done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tbl[mem_addr] <= mem_wdata;
            else        mem_rdata     <= tbl[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (mem_en === 1'b1 && mem_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h/%0d expected=none", mem_addr, mem_wdata);
            end else begin
                chk("mem_write", {22'd0, mem_addr, mem_wdata}, {22'd0, exp_wr.pop_front()});
            end
        end
        if (lk_rvalid === 1'b1) begin
            if (exp_lk.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid actual=%0d expected=none", lk_rdata);
            end else begin
                chk("lk_rdata", {30'd0, lk_rdata}, {30'd0, exp_lk.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_init_writes;
        for (int i = 0; i < 256; i++) exp_wr.push_back({i[7:0], 2'd1});
    endtask

    task automatic wait_init;
        int n = 0;
        while (init_done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("init_cycles", n, 256);
    endtask

    task automatic wait_drain;
        int n = 0;
        while ((exp_wr.size() != 0 || exp_lk.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_left", exp_wr.size() + exp_lk.size(), 0);
    endtask

    task automatic do_lookup(input logic [7:0] idx, input logic [1:0] expv);
        lk_valid = 1'b1;
        lk_idx   = idx;
        #1;
        chk("lk_ready_grant", lk_ready, 1);
        exp_lk.push_back(expv);
        tick();
        lk_valid = 1'b0;
        #1;
        chk("lk_rvalid_set", lk_rvalid, 1);
        tick();
        chk("lk_rvalid_clr", lk_rvalid, 0);
    endtask

    task automatic push_upd(input logic [7:0] idx, input logic tk, input logic [1:0] wexp);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = tk;
        #1;
        chk("upd_ready", upd_ready, 1);
        exp_wr.push_back({idx, wexp});
        tick();
        upd_valid = 1'b0;
    endtask

    logic       h_rdy [8] = '{1, 1, 1, 1, 0, 0, 1, 1};
    logic [2:0] h_cnt [8] = '{0, 1, 2, 3, 4, 4, 3, 3};

    initial begin
        reset = 1'b1; lk_valid = 1'b0; lk_idx = '0;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
        tick();
        tick();
        chk("rst_lk_ready", lk_ready, 0);
        chk("rst_upd_ready", upd_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_lk_rvalid", lk_rvalid, 0);
        chk("rst_lk_rdata", lk_rdata, 0);

        push_init_writes();
        reset = 1'b0;
        lk_valid = 1'b1; lk_idx = 8'h11;
        upd_valid = 1'b1; upd_idx = 8'h01;
        #1;
        chk("init_lk_ready", lk_ready, 0);
        chk("init_upd_ready", upd_ready, 0);
        lk_valid = 1'b0; upd_valid = 1'b0;
        wait_init();
        chk("init_writes_left", exp_wr.size(), 0);

        do_lookup(8'h5A, 2'd1);

        // Ceiling and floor saturation, serialized same-index updates
        push_upd(8'h10, 1'b1, 2'd2);
        push_upd(8'h10, 1'b1, 2'd3);
        push_upd(8'h10, 1'b1, 2'd3);
        wait_drain();
        push_upd(8'h20, 1'b0, 2'd0);
        push_upd(8'h20, 1'b0, 2'd0);
        push_upd(8'h20, 1'b0, 2'd0);
        wait_drain();
        do_lookup(8'h10, 2'd3);
        do_lookup(8'h20, 2'd0);

        // Lookups held high while the queue fills; a push at full is dropped
        for (int k = 0; k < 8; k++) begin
            lk_valid  = 1'b1;
            lk_idx    = 8'h77;
            upd_valid = (k <= 4);
            upd_idx   = (k == 4) ? 8'h60 : 8'h30;
            upd_taken = 1'b1;
            #1;
            chk("held_lk_ready", lk_ready, h_rdy[k]);
            chk("held_upd_ready", upd_ready, h_rdy[k]);
            chk("held_fifo_count", fifo_count, h_cnt[k]);
            if (h_rdy[k]) exp_lk.push_back(2'd1);
            if (k < 4) exp_wr.push_back({8'h30, (k == 0) ? 2'd2 : 2'd3});
            tick();
        end
        lk_valid = 1'b0; upd_valid = 1'b0;
        tick();
        tick();
        tick();
        upd_valid = 1'b1; upd_idx = 8'h40; upd_taken = 1'b1;
        #1;
        chk("pp_upd_ready", upd_ready, 1);
        chk("pp_count_before", fifo_count, 2);
        exp_wr.push_back({8'h40, 2'd2});
        tick();
        upd_valid = 1'b0;
        #1;
        chk("pp_count_after", fifo_count, 2);
        wait_drain();
        do_lookup(8'h30, 2'd3);
        do_lookup(8'h40, 2'd2);
        do_lookup(8'h60, 2'd1);

        // Reset during UPD_WB with three updates queued
        for (int k = 0; k < 3; k++) begin
            lk_valid  = 1'b1;
            lk_idx    = 8'h77;
            upd_valid = 1'b1;
            upd_idx   = 8'h70 + k[7:0];
            upd_taken = 1'b1;
            #1;
            chk("rw_lk_ready", lk_ready, 1);
            exp_lk.push_back(2'd1);
            tick();
        end
        lk_valid = 1'b0; upd_valid = 1'b0;
        tick();
        chk("rw_count", fifo_count, 3);
        chk("rw_in_wb_we", mem_we, 1);
        chk("rw_in_wb_addr", mem_addr, 8'h70);
        reset = 1'b1;
        #1;
        chk("rw_we_gated", mem_we, 0);
        chk("rw_en_gated", mem_en, 0);
        chk("rw_count_zero", fifo_count, 0);
        chk("rw_exp_empty", exp_wr.size(), 0);
        tick();
        push_init_writes();
        reset = 1'b0;
        #1;
        chk("rs_init_done", init_done, 0);
        chk("rs_fifo_count", fifo_count, 0);
        chk("rs_sweep_addr", mem_addr, 0);
        wait_init();
        chk("rs_fifo_after", fifo_count, 0);
        do_lookup(8'h70, 2'd1);
        do_lookup(8'h72, 2'd1);
        for (int i = 0; i < 10; i++) tick();
        chk("final_exp_wr", exp_wr.size(), 0);
        chk("final_exp_lk", exp_lk.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_pht_port_ctrl.md
Name: bp_pht_port_ctrl

Overview:
- Controls a single-port pattern-history-table memory (256 x 2-bit counters by default) shared between the fetch-stage prediction lookup and the branch-resolution update path.
- Runs a post-reset initialization sweep of the table.
- Buffers resolved-branch updates in a small FIFO and sequences each update as a read-modify-write.
- Arbitrates every port cycle between lookups and updates.

Parameters:
- IDX_BITS, 8, table index width; table holds 2^IDX_BITS entries.
- CTR_BITS, 2, saturating counter width.
- FIFO_DEPTH, 4, update FIFO entries; must be a power of two.
- INIT_VAL, 1, counter value written by the init sweep (weakly not taken).

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- lk_valid  in  1  fetch requests a counter read.
- lk_idx  in  IDX_BITS  lookup index.
- lk_ready  out  1  lookup granted this cycle (combinational).
- lk_rvalid  out  1  lookup data valid (one cycle after grant).
- lk_rdata  out  CTR_BITS  counter value returned for the granted lookup.
- upd_valid  in  1  resolved branch update request.
- upd_idx  in  IDX_BITS  index to update.
- upd_taken  in  1  actual branch outcome.
- upd_ready  out  1  FIFO can accept (combinational).
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  IDX_BITS  memory address.
- mem_wdata  out  CTR_BITS  memory write data.
- mem_rdata  in  CTR_BITS  memory read data; valid the cycle after a read is issued.
- init_done  out  1  sweep complete.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: state INIT, sweep pointer 0, FIFO emptied.
  - Registered outputs reset to 0: init_done, lk_rvalid, lk_rdata.
  - Combinational outputs are forced to 0 while reset is asserted: lk_ready, upd_ready, mem_en, mem_we, mem_addr, mem_wdata.
  - fifo_count reads 0.
- A reset asserted mid-operation discards queued updates and restarts the sweep.
- States: INIT, IDLE, UPD_WB.
- INIT:
  - Each cycle: mem_en=1, mem_we=1, mem_addr=sweep pointer, mem_wdata=INIT_VAL; pointer increments.
  - After writing address 2^IDX_BITS-1, go to IDLE. init_done rises on the first IDLE cycle; the sweep takes exactly 2^IDX_BITS cycles.
  - lk_ready=0 and upd_ready=0 throughout INIT.
- upd_ready = init_done && fifo_count<FIFO_DEPTH. A push occurs on upd_valid && upd_ready, storing {upd_idx, upd_taken}.
- IDLE arbitration, one port operation per cycle:
  - If lk_valid and FIFO not full: grant lookup. lk_ready=1, mem_en=1, mem_we=0, mem_addr=lk_idx. Next cycle lk_rvalid=1 and lk_rdata=mem_rdata.
  - Else if FIFO not empty: issue read of the head index (mem_en=1, mem_we=0) and go to UPD_WB. lk_ready=0.
  - Else: port idle, mem_en=0.
  - Lookup beats update unless the FIFO is full; when full, update wins and lk_ready=0.
- UPD_WB:
  - Compute new = taken ? (mem_rdata==max ? max : mem_rdata+1) : (mem_rdata==0 ? 0 : mem_rdata-1), where max = 2^CTR_BITS-1.
  - Drive mem_we=1, mem_addr=head index, mem_wdata=new. Pop FIFO; return to IDLE.
  - lk_ready=0 in this state.
- An update occupies the port for 2 cycles. Updates to the same index are strictly serialized, so a second update reads the first one's result. There is no forwarding from queued updates to lookups (stale predictions are acceptable).
- A lookup granted the cycle after UPD_WB returns the written value.
- Push and pop in the same cycle leave fifo_count unchanged. FIFO pointers wrap modulo FIFO_DEPTH.
- lk_rvalid deasserts the cycle after a non-granted or idle cycle. lk_rdata holds its last value when lk_rvalid=0.

Test Plan:
- Reset, then idle -> exactly 256 write cycles to addr 0..255 with wdata=1; init_done=1 at cycle 256 after reset release. A lookup of idx 0x5A then returns lk_rdata=1.
- Push update {idx 0x10, taken=1} twice with no lookups -> writes of 2 then 3 to addr 0x10. A third taken update writes 3 (saturate).
- Three not-taken updates to idx 0x20 -> writes of 0, 0, 0 (floor saturation).
- lk_valid held high continuously while 4 updates are pushed -> lookups granted until fifo_count=4. Then lk_ready=0 for 2 cycles while one update drains, then lookups resume.
- Same-cycle push and pop with fifo_count=2 -> fifo_count stays 2. Pushing with fifo_count=4 -> upd_ready=0 and the push is ignored.
- Reset asserted in UPD_WB with 3 queued updates -> fifo_count=0, init_done=0, sweep restarts at addr 0, and no queued update is ever written.
